truth_table_checker: RTL and testbench
======================================

# truth_table_checker

Sequential exhaustive checker for small combinational gate modules (NOR, AND, etc.). On `start`, it walks every input combination, drives it onto the DUT and waits a programmable settle time. It then samples the DUT output, compares it against an expected truth-table vector and reports the observed table, the mismatch count, the first failing index and pass/fail. It is the response-checking end of the gate test flow: stimulus and checking move into synthesizable hardware instead of a `$monitor` bench.

## Interface
- `N_IN`, default 2: number of DUT inputs; the table has 2**N_IN entries.
- `SETTLE_CYCLES`, default 1: cycles stimulus is held before sampling; legal range ≥ 1.
- `clk` input, 1 bit: the single clock; all state changes on its rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: request a run; accepted only in IDLE.
- `expected` input, 2**N_IN bits: expected output; bit i is the output for stimulus value i. Latched at start.
- `resp` input, 1 bit: DUT output.
- `stim` output, N_IN bits: DUT input vector; MSB is the first gate input (x), LSB the last (y).
- `busy` output, 1 bit: high from the cycle after `start` is accepted through the DONE cycle.
- `done` output, 1 bit: one-cycle pulse in the DONE state.
- `pass` output, 1 bit: `err_count == 0`; valid from `done` until the next accepted `start`.
- `observed` output, 2**N_IN bits: captured DUT table; bit i is `resp` sampled with `stim == i`.
- `err_count` output, N_IN+1 bits: number of mismatching entries.
- `first_err` output, N_IN bits: lowest failing index.
- `first_err_vld` output, 1 bit: `first_err` holds a real value.

## Operation
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- **Reset values:** state IDLE; `stim` 0; `busy` 0; `done` 0; `pass` 0; `observed` 0; `err_count` 0; `first_err` 0; `first_err_vld` 0.
- **IDLE:**
  - `start` = 1 latches `expected`.
  - Clears `observed`, `err_count`, `first_err`, `first_err_vld` and `pass`.
  - Sets `stim` = 0, loads the settle counter with SETTLE_CYCLES and goes to SETTLE.
- **SETTLE:** the counter decrements each cycle. State holds for exactly SETTLE_CYCLES cycles, then moves to SAMPLE.
- **SAMPLE (one cycle):** at the closing edge:
  - `observed[stim]` <= `resp`.
  - On mismatch with `expected[stim]`: `err_count` increments. If `first_err_vld` = 0, then `first_err` <= `stim` and `first_err_vld` <= 1.
  - If `stim` == 2**N_IN−1, go to DONE. Otherwise `stim` increments, the counter reloads and the FSM goes to SETTLE.
- **DONE (one cycle):**
  - `done` = 1.
  - `pass` registers `err_count == 0`, including the final sample's contribution.
  - `stim` holds its last value. Next state is IDLE.
- `start` is ignored in SETTLE, SAMPLE and DONE; it is never queued.
- `stim` does not wrap; it stops at the all-ones value.
- `err_count` cannot overflow: N_IN+1 bits holds up to 2**N_IN.
- Results hold in IDLE until the next accepted `start`.
- Reset mid-run: asynchronous return to reset values; the partial run is discarded and there is no `done`.

## Timing
- Each vector takes SETTLE_CYCLES+1 cycles.
- `done` is high in cycle 2**N_IN·(SETTLE_CYCLES+1)+1 after the edge that accepted `start`. With defaults that is cycle 9.
- `stim` changes only at the SAMPLE→SETTLE edge. The DUT therefore sees each value stable for the full SETTLE+SAMPLE window, SETTLE_CYCLES+1 cycles.
- `resp` must be settled at the SAMPLE closing edge; it has no other sampling point.
- Earliest restart: `start` in the IDLE cycle after DONE.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `gate_chk_pkg`:
  - State enum.
  - Expected-table constants: NOR2 = 4'b0001, AND2 = 4'b1000, OR2 = 4'b1110, NAND2 = 4'b0111, XOR2 = 4'b0110.
- One natural sub-module, `settle_counter`: loadable down-counter with a `zero` flag, parameterised by SETTLE_CYCLES.
- Mismatch/first-error logic stays in the top module.

## Test plan
- **NOR pass:** `expected` = 4'b0001, `resp` = NOR(stim[1], stim[0]), defaults. Required:
  - `stim` sequence 00, 01, 10, 11.
  - `done` in cycle 9; `observed` = 0001; `err_count` = 0; `pass` = 1; `first_err_vld` = 0.
- **Wrong table:** `expected` = 4'b1000 (AND) with the NOR responder. Required: `observed` = 0001, `err_count` = 2, `first_err` = 0, `first_err_vld` = 1, `pass` = 0.
- **Stuck-at-1 DUT:** `resp` = 1, `expected` = 0001. Required: `observed` = 1111, `err_count` = 3, `first_err` = 1, `pass` = 0.
- **Settle and restart:** SETTLE_CYCLES = 3, `start` re-pulsed during SETTLE and in the DONE cycle.
  - Required: both pulses ignored; `done` only in cycle 17; each `stim` value held 4 cycles.
  - A `start` in the following IDLE cycle launches a fresh run with results cleared.
- **Reset mid-run:** `rst_n` low while `stim` = 10 in SETTLE. Required: all outputs return to reset values immediately, and no `done` occurs until a new `start`.
- **Width check:** N_IN = 3, `resp` = 0, `expected` = 8'hFF. Required: `err_count` = 8 (4'b1000), `first_err` = 0, `done` in cycle 17.

Source files
------------

// File: rtl/gate_chk_pkg.sv
// Shared types and reference truth tables for the gate response checker.
// Table bit i is the gate output for stimulus value i (MSB of stim = x).
package gate_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } chk_state_e;

  localparam logic [3:0] TT_NOR2  = 4'b0001;
  localparam logic [3:0] TT_AND2  = 4'b1000;
  localparam logic [3:0] TT_OR2   = 4'b1110;
  localparam logic [3:0] TT_NAND2 = 4'b0111;
  localparam logic [3:0] TT_XOR2  = 4'b0110;

endpackage

// File: rtl/truth_table_checker_settle_counter.sv
// Loadable settle down-counter. The zero flag marks the SETTLE cycle whose
// decrement brings the count to zero, so SETTLE lasts exactly SETTLE_CYCLES.
module settle_counter #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int CW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(SETTLE_CYCLES);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == CW'(1));

endmodule

// File: rtl/truth_table_checker.sv
// Exhaustive response checker: walks every stimulus value, samples the gate
// output after a settle window and scores it against an expected table.
//
// state  | meaning
// IDLE   | results held; waiting for start
// SETTLE | stim driven, counting down the settle window
// SAMPLE | capture resp, score it, advance stim or finish
// DONE   | one-cycle done pulse, pass valid
module truth_table_checker
  import gate_chk_pkg::*;
#(
  parameter int N_IN          = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   expected,
  input  logic                 resp,
  output logic [N_IN-1:0]      stim,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2**N_IN-1:0]   observed,
  output logic [N_IN:0]        err_count,
  output logic [N_IN-1:0]      first_err,
  output logic                 first_err_vld
);

  localparam int N_VEC = 2**N_IN;

  chk_state_e        state_q, state_d;
  logic [N_VEC-1:0]  exp_q;
  logic              cnt_load;
  logic              cnt_zero;
  logic              mism;
  logic              last_vec;

  assign last_vec = (stim == N_IN'(N_VEC - 1));
  assign mism     = (resp != exp_q[stim]);

  settle_counter #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_settle (
    .clk  (clk),
    .rst_n(rst_n),
    .load (cnt_load),
    .dec  (state_q == ST_SETTLE),
    .zero (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_SETTLE;
          cnt_load = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (cnt_zero) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (last_vec) begin
          state_d = ST_DONE;
        end else begin
          state_d  = ST_SETTLE;
          cnt_load = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q         <= '0;
      stim          <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      observed      <= '0;
      err_count     <= '0;
      first_err     <= '0;
      first_err_vld <= 1'b0;
    end else begin
      busy <= (state_d != ST_IDLE);
      done <= (state_d == ST_DONE);
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            exp_q         <= expected;
            stim          <= '0;
            pass          <= 1'b0;
            observed      <= '0;
            err_count     <= '0;
            first_err     <= '0;
            first_err_vld <= 1'b0;
          end
        end
        ST_SAMPLE: begin
          observed[stim] <= resp;
          if (mism) begin
            err_count <= err_count + 1'b1;
            if (!first_err_vld) begin
              first_err     <= stim;
              first_err_vld <= 1'b1;
            end
          end
          // pass is resolved here so it already covers the last sample in DONE
          if (last_vec) pass <= (err_count == '0) && !mism;
          else          stim <= stim + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker: default, long-settle and 3-input
// instances driven one after another from a single stimulus sequence.
module tb_truth_table_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  // default instance: N_IN=2, SETTLE_CYCLES=1
  logic       start0, resp0, mode0;
  logic [3:0] exp0, obs0;
  logic [1:0] stim0, fe0;
  logic [2:0] err0;
  logic       busy0, done0, pass0, fev0;
  assign resp0 = mode0 ? 1'b1 : ~(stim0[1] | stim0[0]);

  truth_table_checker u_d0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .expected(exp0), .resp(resp0),
    .stim(stim0), .busy(busy0), .done(done0), .pass(pass0), .observed(obs0),
    .err_count(err0), .first_err(fe0), .first_err_vld(fev0)
  );

  // long settle instance: SETTLE_CYCLES=3, NOR responder
  logic       start1, resp1;
  logic [3:0] exp1, obs1;
  logic [1:0] stim1, fe1;
  logic [2:0] err1;
  logic       busy1, done1, pass1, fev1;
  assign resp1 = ~(stim1[1] | stim1[0]);

  truth_table_checker #(.N_IN(2), .SETTLE_CYCLES(3)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .expected(exp1), .resp(resp1),
    .stim(stim1), .busy(busy1), .done(done1), .pass(pass1), .observed(obs1),
    .err_count(err1), .first_err(fe1), .first_err_vld(fev1)
  );

  // 3-input instance, responder stuck at 0
  logic       start2, resp2;
  logic [7:0] exp2, obs2;
  logic [2:0] stim2, fe2;
  logic [3:0] err2;
  logic       busy2, done2, pass2, fev2;

  truth_table_checker #(.N_IN(3), .SETTLE_CYCLES(1)) u_d2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .expected(exp2), .resp(resp2),
    .stim(stim2), .busy(busy2), .done(done2), .pass(pass2), .observed(obs2),
    .err_count(err2), .first_err(fe2), .first_err_vld(fev2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Launches a run on the default instance and returns the cycle done is seen.
  task automatic run0(input logic [3:0] e, input bit chk_stim, output int cyc);
    @(negedge clk);
    exp0   = e;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    cyc    = 1;
    while (!done0 && cyc < 200) begin
      if (chk_stim) chk("stim0_seq", 32'(stim0), 32'((cyc - 1) / 2));
      @(negedge clk);
      cyc++;
    end
  endtask

  int cyc;
  int dcount;

  initial begin
    rst_n  = 1'b0;
    start0 = 1'b0; exp0 = '0; mode0 = 1'b0;
    start1 = 1'b0; exp1 = '0;
    start2 = 1'b0; exp2 = '0; resp2 = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_stim",  32'(stim0), 32'h0);
    chk("rst_busy",  32'(busy0), 32'h0);
    chk("rst_done",  32'(done0), 32'h0);
    chk("rst_pass",  32'(pass0), 32'h0);
    chk("rst_obs",   32'(obs0),  32'h0);
    chk("rst_err",   32'(err0),  32'h0);
    chk("rst_fev",   32'(fev0),  32'h0);
    rst_n = 1'b1;

    // NOR pass
    run0(4'b0001, 1'b1, cyc);
    chk("nor_done_cyc", 32'(cyc),   32'd9);
    chk("nor_obs",      32'(obs0),  32'h1);
    chk("nor_err",      32'(err0),  32'h0);
    chk("nor_pass",     32'(pass0), 32'h1);
    chk("nor_fev",      32'(fev0),  32'h0);
    chk("nor_busy",     32'(busy0), 32'h1);
    chk("nor_stim_end", 32'(stim0), 32'h3);
    @(negedge clk);
    chk("nor_done_pulse", 32'(done0), 32'h0);
    chk("nor_idle_busy",  32'(busy0), 32'h0);
    chk("nor_hold_pass",  32'(pass0), 32'h1);

    // wrong table (AND) against NOR responder
    run0(4'b1000, 1'b0, cyc);
    chk("and_done_cyc", 32'(cyc),   32'd9);
    chk("and_obs",      32'(obs0),  32'h1);
    chk("and_err",      32'(err0),  32'h2);
    chk("and_fe",       32'(fe0),   32'h0);
    chk("and_fev",      32'(fev0),  32'h1);
    chk("and_pass",     32'(pass0), 32'h0);

    // stuck-at-1 responder
    mode0 = 1'b1;
    run0(4'b0001, 1'b0, cyc);
    chk("sa1_obs",  32'(obs0),  32'hF);
    chk("sa1_err",  32'(err0),  32'h3);
    chk("sa1_fe",   32'(fe0),   32'h1);
    chk("sa1_fev",  32'(fev0),  32'h1);
    chk("sa1_pass", 32'(pass0), 32'h0);
    mode0 = 1'b0;

    // settle=3 with ignored start pulses, then an immediate restart
    @(negedge clk);
    exp1   = 4'b0001;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    cyc    = 1;
    while (!done1 && cyc < 200) begin
      chk("s3_stim_hold", 32'(stim1), 32'((cyc - 1) / 4));
      start1 = (cyc == 2);
      @(negedge clk);
      cyc++;
    end
    chk("s3_done_cyc", 32'(cyc),   32'd17);
    chk("s3_pass",     32'(pass1), 32'h1);
    chk("s3_obs",      32'(obs1),  32'h1);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("s3_no_redone", 32'(done1), 32'h0);
    chk("s3_idle_busy", 32'(busy1), 32'h0);
    chk("s3_hold_obs",  32'(obs1),  32'h1);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("s3_restart_busy", 32'(busy1), 32'h1);
    chk("s3_restart_obs",  32'(obs1),  32'h0);
    chk("s3_restart_pass", 32'(pass1), 32'h0);
    chk("s3_restart_stim", 32'(stim1), 32'h0);
    cyc = 1;
    while (!done1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("s3_rerun_cyc",  32'(cyc),   32'd17);
    chk("s3_rerun_pass", 32'(pass1), 32'h1);

    // reset mid-run while stim = 10 in SETTLE
    @(negedge clk);
    exp0   = 4'b0001;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    cyc    = 1;
    while (stim0 != 2'b10 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("mr_reach_cyc", 32'(cyc), 32'd5);
    rst_n = 1'b0;
    #1;
    chk("mr_stim", 32'(stim0), 32'h0);
    chk("mr_busy", 32'(busy0), 32'h0);
    chk("mr_done", 32'(done0), 32'h0);
    chk("mr_pass", 32'(pass0), 32'h0);
    chk("mr_obs",  32'(obs0),  32'h0);
    chk("mr_err",  32'(err0),  32'h0);
    chk("mr_fe",   32'(fe0),   32'h0);
    chk("mr_fev",  32'(fev0),  32'h0);
    @(negedge clk);
    rst_n  = 1'b1;
    dcount = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done0) dcount++;
    end
    chk("mr_no_done", 32'(dcount), 32'h0);
    chk("mr_idle_busy", 32'(busy0), 32'h0);

    // 3-input width check
    @(negedge clk);
    exp2   = 8'hFF;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    cyc    = 1;
    while (!done2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("w3_done_cyc", 32'(cyc),   32'd17);
    chk("w3_err",      32'(err2),  32'h8);
    chk("w3_fe",       32'(fe2),   32'h0);
    chk("w3_fev",      32'(fev2),  32'h1);
    chk("w3_obs",      32'(obs2),  32'h0);
    chk("w3_pass",     32'(pass2), 32'h0);
    chk("w3_stim_end", 32'(stim2), 32'h7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
